// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with 2-entry skid, flush bubbles, optional PIPE_STAGE_STATS_EN counters
module pipe_stage_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 118
`ifdef PIPE_STAGE_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  , output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic in_fire, out_fire, load_main, load_skid, pop_skid;
  assign in_ready  = (state_q != FULL) & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  always_comb begin
    load_main   = in_fire & ((state_q == EMPTY) | ((state_q == ONE) & out_fire));
    load_skid   = in_fire & (state_q == ONE) & ~out_fire;
    pop_skid    = ~flush & (state_q == FULL) & out_fire;
    state_d     = flush ? EMPTY : state_t'(state_q + {1'b0, in_fire} - {1'b0, out_fire});
    main_ctrl_d = load_main ? in_ctrl : pop_skid ? skid_ctrl_q : main_ctrl_q;
    main_data_d = load_main ? in_data : pop_skid ? skid_data_q : main_data_q;
    skid_ctrl_d = load_skid ? in_ctrl : skid_ctrl_q;
    skid_data_d = load_skid ? in_data : skid_data_q;
  end
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end
`ifdef PIPE_STAGE_STATS_EN
  logic [STAT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    stall_d = stall_q + {{(STAT_W-1){1'b0}}, out_valid & ~out_ready & ~&stall_q};
    flush_d = flush_q + {{(STAT_W-1){1'b0}}, flush & out_valid & ~&flush_q};
  end
  always_ff @(negedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif
endmodule
